// File: rtl/controller_dram_arbiter.sv
// controller_dram_arbiter
// Two Avalon-MM requesters share one single-port RAM. The arbiter issues at
// most one RAM access per clock. Read data comes back one cycle after the
// accept and is tagged to the requester that issued the read.
//
// Handshake: a requester asserts read and/or write with a stable address and
// data. When it sees waitrequest=0 at a rising edge, the access is accepted at
// that edge and the requester may change its request. The RAM samples
// ram_address at the same edge. readdatavalid is high for exactly one cycle,
// the cycle after a read accept, and only on the owning port.
module controller_dram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // Registered arbitration and read-return state
    logic               r_last_grant;   // 0 = m0, 1 = m1
    logic               r_rd_pend;
    logic               r_rd_owner;
    logic [3:0]         r_starve_cnt;
    logic [ADDR_W-1:0]  r_ram_address;  // held on the RAM when idle

    // Request decode and grant
    logic               w_m0_req;
    logic               w_m1_req;
    logic               w_gnt_valid;
    logic               w_gnt_sel;

    // Muxed fields of the selected requester
    logic [ADDR_W-1:0]  w_sel_address;
    logic [DATA_W/8-1:0] w_sel_byteenable;
    logic [DATA_W-1:0]  w_sel_writedata;
    logic               w_sel_write;
    logic               w_accept_read;

    assign w_m0_req = m0_read | m0_write;
    assign w_m1_req = m1_read | m1_write;

    // Grant selection: sole requester wins; ties go by round-robin or by
    // m0 priority with a starvation guard for m1. Nothing is granted in reset.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_sel   = r_last_grant;
        if (reset_n) begin
            if (w_m0_req && !w_m1_req) begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = 1'b0;
            end else if (!w_m0_req && w_m1_req) begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = 1'b1;
            end else if (w_m0_req && w_m1_req) begin
                w_gnt_valid = 1'b1;
                if (FIXED_PRIO == 0) begin
                    w_gnt_sel = ~r_last_grant;
                end else begin
                    w_gnt_sel = (r_starve_cnt == C_STARVE_LIMIT);
                end
            end
        end
    end

    // Route the selected requester's fields toward the RAM
    always_comb begin
        w_sel_address    = w_gnt_sel ? m1_address    : m0_address;
        w_sel_byteenable = w_gnt_sel ? m1_byteenable : m0_byteenable;
        w_sel_writedata  = w_gnt_sel ? m1_writedata  : m0_writedata;
        w_sel_write      = w_gnt_sel ? m1_write      : m0_write;
    end

    // A grant is an accept at the next edge; write wins over a simultaneous read
    assign w_accept_read = w_gnt_valid & ~w_sel_write;

    // RAM-side and requester-side outputs
    always_comb begin
        ram_address      = w_gnt_valid ? w_sel_address : r_ram_address;
        ram_byteenable   = w_sel_byteenable;
        ram_writedata    = w_sel_writedata;
        ram_chipselect   = w_gnt_valid;
        ram_write        = w_gnt_valid & w_sel_write;
        ram_clken        = reset_n;
        m0_waitrequest   = ~(w_gnt_valid & ~w_gnt_sel);
        m1_waitrequest   = ~(w_gnt_valid &  w_gnt_sel);
        m0_readdata      = ram_readdata;
        m1_readdata      = ram_readdata;
        m0_readdatavalid = r_rd_pend & ~r_rd_owner;
        m1_readdatavalid = r_rd_pend &  r_rd_owner;
    end

    // Track the last winner and the one-deep outstanding read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_rd_pend <= w_accept_read;
            if (w_gnt_valid) begin
                r_last_grant <= w_gnt_sel;
            end
            if (w_accept_read) begin
                r_rd_owner <= w_gnt_sel;
            end
        end
    end

    // Count consecutive m0 wins while m1 waits; saturates at the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!w_m1_req || (w_gnt_valid && w_gnt_sel)) begin
            r_starve_cnt <= 4'd0;
        end else if (w_gnt_valid && !w_gnt_sel && (r_starve_cnt != C_STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Remember the last issued address so the RAM address is stable when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_address <= '0;
        end else if (w_gnt_valid) begin
            r_ram_address <= w_sel_address;
        end
    end

    // At most one requester may be released in any cycle
    a_single_grant: assert property (@(posedge clk) disable iff (!reset_n)
        !(!m0_waitrequest && !m1_waitrequest));

    // Read data is only ever tagged to one owner
    a_single_rdv: assert property (@(posedge clk) disable iff (!reset_n)
        !(m0_readdatavalid && m1_readdatavalid));

endmodule

// File: tb/tb_controller_dram_arbiter.sv
// Bench for controller_dram_arbiter: instance 0 is round-robin, instance 1
// is fixed priority with STARVE_LIMIT=4. Each instance has its own RAM model.
module tb_controller_dram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [1:0][9:0]  m0_address, m1_address;
  logic [1:0][3:0]  m0_byteenable, m1_byteenable;
  logic [1:0]       m0_read, m0_write, m1_read, m1_write;
  logic [1:0][31:0] m0_writedata, m1_writedata;
  wire  [1:0]       m0_waitrequest, m1_waitrequest;
  wire  [1:0]       m0_readdatavalid, m1_readdatavalid;
  wire  [1:0][31:0] m0_readdata, m1_readdata;
  wire  [1:0][9:0]  ram_address;
  wire  [1:0][3:0]  ram_byteenable;
  wire  [1:0]       ram_chipselect, ram_write, ram_clken;
  wire  [1:0][31:0] ram_writedata, ram_readdata;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [1024];
    logic [9:0]  addr_q;

    controller_dram_arbiter #(
      .ADDR_W(10), .DATA_W(32), .FIXED_PRIO(g), .STARVE_LIMIT(4)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address[g]), .m0_byteenable(m0_byteenable[g]),
      .m0_read(m0_read[g]), .m0_write(m0_write[g]), .m0_writedata(m0_writedata[g]),
      .m0_waitrequest(m0_waitrequest[g]), .m0_readdata(m0_readdata[g]),
      .m0_readdatavalid(m0_readdatavalid[g]),
      .m1_address(m1_address[g]), .m1_byteenable(m1_byteenable[g]),
      .m1_read(m1_read[g]), .m1_write(m1_write[g]), .m1_writedata(m1_writedata[g]),
      .m1_waitrequest(m1_waitrequest[g]), .m1_readdata(m1_readdata[g]),
      .m1_readdatavalid(m1_readdatavalid[g]),
      .ram_address(ram_address[g]), .ram_byteenable(ram_byteenable[g]),
      .ram_chipselect(ram_chipselect[g]), .ram_write(ram_write[g]),
      .ram_writedata(ram_writedata[g]), .ram_clken(ram_clken[g]),
      .ram_readdata(ram_readdata[g])
    );

    // Single-port RAM: registered address, unregistered output, new-data
    always @(posedge clk) begin
      if (ram_clken[g]) begin
        if (ram_chipselect[g] && ram_write[g]) begin
          for (int b = 0; b < 4; b++) begin
            if (ram_byteenable[g][b]) mem[ram_address[g]][8*b +: 8] <= ram_writedata[g][8*b +: 8];
          end
        end
        addr_q <= ram_address[g];
      end
    end
    assign ram_readdata[g] = mem[addr_q];
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
  } cmd_t;

  cmd_t        cq0[$], cq1[$];
  logic [63:0] exp_q0[$], exp_q1[$];   // {due cycle, data}
  int          gnt_log[$];
  int          cyc_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          run_cycles;
  logic [63:0] e0, e1;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [9:0] a,
                              input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.a = a; c.be = be; c.d = d; c.exp = exp;
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic present();
    if (cq0.size() != 0) begin
      m0_address[0] = cq0[0].a; m0_byteenable[0] = cq0[0].be; m0_writedata[0] = cq0[0].d;
      m0_read[0] = cq0[0].rd; m0_write[0] = cq0[0].wr;
    end else begin
      m0_read[0] = 1'b0; m0_write[0] = 1'b0;
    end
    if (cq1.size() != 0) begin
      m1_address[0] = cq1[0].a; m1_byteenable[0] = cq1[0].be; m1_writedata[0] = cq1[0].d;
      m1_read[0] = cq1[0].rd; m1_write[0] = cq1[0].wr;
    end else begin
      m1_read[0] = 1'b0; m1_write[0] = 1'b0;
    end
  endtask

  // Holds each head request until it sees waitrequest low, then pops it
  task automatic run(input int budget);
    cmd_t c;
    run_cycles = 0;
    while ((cq0.size() != 0 || cq1.size() != 0) && run_cycles < budget) begin
      present();
      @(negedge clk);
      if (cq0.size() != 0 && !m0_waitrequest[0]) begin
        c = cq0.pop_front();
        gnt_log.push_back(0);
        if (c.rd && !c.wr) exp_q0.push_back({32'(cyc_cnt + 1), c.exp});
      end
      if (cq1.size() != 0 && !m1_waitrequest[0]) begin
        c = cq1.pop_front();
        gnt_log.push_back(1);
        if (c.rd && !c.wr) exp_q1.push_back({32'(cyc_cnt + 1), c.exp});
      end
      @(posedge clk); #1;
      run_cycles++;
    end
    m0_read[0] = 1'b0; m0_write[0] = 1'b0; m1_read[0] = 1'b0; m1_write[0] = 1'b0;
    chk("run_drained", 64'(cq0.size() + cq1.size()), 64'd0);
    cq0.delete(); cq1.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (m0_readdatavalid[0]) begin
      chk("m0_rdv_expected", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) begin
        e0 = exp_q0.pop_front();
        chk("m0_rd_data", 64'(m0_readdata[0]), 64'(e0[31:0]));
        chk("m0_rd_cycle", 64'(cyc_cnt), 64'(e0[63:32]));
      end
    end
    if (m1_readdatavalid[0]) begin
      chk("m1_rdv_expected", 64'(exp_q1.size() != 0), 64'd1);
      if (exp_q1.size() != 0) begin
        e1 = exp_q1.pop_front();
        chk("m1_rd_data", 64'(m1_readdata[0]), 64'(e1[31:0]));
        chk("m1_rd_cycle", 64'(cyc_cnt), 64'(e1[63:32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
    m0_read = '0; m0_write = '0; m1_read = '0; m1_write = '0;
    m0_read[0] = 1'b1; m1_write[1] = 1'b1;   // requests during reset must be ignored
    #1;
    chk("rst_m0_wait", 64'(m0_waitrequest), 64'h3);
    chk("rst_m1_wait", 64'(m1_waitrequest), 64'h3);
    chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'h0);
    chk("rst_cs", 64'(ram_chipselect), 64'h0);
    chk("rst_wr", 64'(ram_write), 64'h0);
    chk("rst_clken", 64'(ram_clken), 64'h0);
    m0_read = '0; m1_write = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'hF);
    chk("idle_cs", 64'(ram_chipselect), 64'h0);
    chk("idle_clken", 64'(ram_clken), 64'h3);

    // Write then read same address, no wait cycles, new data returned
    gnt_log.delete();
    cq0.push_back(mk(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 32'h0));
    cq0.push_back(mk(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 32'hDEADBEEF));
    run(20);
    chk("t1_cycles", 64'(run_cycles), 64'd2);
    chk("t1_ngrants", 64'(gnt_log.size()), 64'd2);
    chk("t1_g0", 64'(gnt_log[0]), 64'd0);
    chk("t1_g1", 64'(gnt_log[1]), 64'd0);
    repeat (2) @(posedge clk); #1;

    // Byte lanes at the top address
    cq0.push_back(mk(1'b0, 1'b1, 10'h3FF, 4'hF, 32'h11223344, 32'h0));
    cq0.push_back(mk(1'b0, 1'b1, 10'h3FF, 4'h8, 32'hAA000000, 32'h0));
    cq0.push_back(mk(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0, 32'hAA223344));
    run(20);
    @(posedge clk); #1;
    chk("hold_addr", 64'(ram_address[0]), 64'h3FF);
    chk("hold_cs", 64'(ram_chipselect[0]), 64'd0);
    @(posedge clk); #1;

    // Read and write together counts as a write only
    cq0.push_back(mk(1'b1, 1'b1, 10'h010, 4'hF, 32'h5, 32'h0));
    cq0.push_back(mk(1'b1, 1'b0, 10'h010, 4'hF, 32'h0, 32'h5));
    run(20);
    repeat (2) @(posedge clk); #1;

    // Round-robin: preload, reset, then both masters read together
    for (int i = 0; i < 4; i++) begin
      cq0.push_back(mk(1'b0, 1'b1, 10'(10'h020 + i), 4'hF, 32'hA0000000 + 32'(i), 32'h0));
      cq1.push_back(mk(1'b0, 1'b1, 10'(10'h030 + i), 4'hF, 32'hB0000000 + 32'(i), 32'h0));
    end
    run(40);
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      cq0.push_back(mk(1'b1, 1'b0, 10'(10'h020 + i), 4'hF, 32'h0, 32'hA0000000 + 32'(i)));
      cq1.push_back(mk(1'b1, 1'b0, 10'(10'h030 + i), 4'hF, 32'h0, 32'hB0000000 + 32'(i)));
    end
    run(40);
    chk("t3_cycles", 64'(run_cycles), 64'd8);
    chk("t3_ngrants", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t3_grant", 64'(gnt_log[i]), 64'(i % 2));
    repeat (3) @(posedge clk); #1;

    // Fixed priority with starvation guard on instance 1
    m0_address[1] = 10'h001; m1_address[1] = 10'h002;
    m0_read[1] = 1'b1; m1_read[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_grant", 64'({m1_waitrequest[1], m0_waitrequest[1]}), (i % 5 == 4) ? 64'h1 : 64'h2);
      @(posedge clk); #1;
    end
    m0_read[1] = 1'b0; m1_read[1] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset right after a read accept discards the pending read
    cq0.push_back(mk(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 32'hDEADBEEF));
    run(5);
    chk("t6_rdv_pending", 64'(m0_readdatavalid[0]), 64'd1);
    reset_n = 1'b0;
    exp_q0.delete();
    m0_read[0] = 1'b1; m1_write[0] = 1'b1;
    #1;
    chk("t6_wait", 64'({m0_waitrequest[0], m1_waitrequest[0]}), 64'h3);
    chk("t6_rdv", 64'({m0_readdatavalid[0], m1_readdatavalid[0]}), 64'h0);
    chk("t6_cs_wr", 64'({ram_chipselect[0], ram_write[0]}), 64'h0);
    chk("t6_clken", 64'(ram_clken[0]), 64'd0);
    repeat (2) @(posedge clk);
    m0_read[0] = 1'b0; m1_write[0] = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    chk("exp_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controller_dram_arbiter.md
# controller_dram_arbiter

Two-master arbiter that shares the single-port 1024×32 on-chip data RAM between two Avalon-MM requesters, for example the CPU data master and a DMA/peripheral master. It issues at most one RAM access per clock and returns read data with fixed one-cycle latency, tagged to the requester that issued it. It sits directly in front of the RAM's clocked address/byteenable/write port. The RAM output is unregistered, so read data is valid the cycle after the address is sampled.

## Interface
Parameters:
- ADDR_W, 10, word address width; RAM depth is 2**ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = m0 has priority, with starvation guard.
- STARVE_LIMIT, 4, in FIXED_PRIO=1, the maximum number of consecutive m0 grants while m1 is requesting; range 1..15.

Ports:
- clk, in, 1, the only clock.
- reset_n, in, 1, asynchronous, active-low reset.
- mX_address, in, ADDR_W, requester X word address (X = 0, 1).
- mX_byteenable, in, DATA_W/8, write byte lanes.
- mX_read, in, 1, read request.
- mX_write, in, 1, write request.
- mX_writedata, in, DATA_W, write data.
- mX_waitrequest, out, 1, request is not accepted this cycle.
- mX_readdata, out, DATA_W, read data.
- mX_readdatavalid, out, 1, mX_readdata is valid this cycle.
- ram_address, out, ADDR_W, to the RAM.
- ram_byteenable, out, DATA_W/8, to the RAM.
- ram_chipselect, out, 1, to the RAM.
- ram_write, out, 1, to the RAM.
- ram_writedata, out, DATA_W, to the RAM.
- ram_clken, out, 1, RAM clock enable.
- ram_readdata, in, DATA_W, RAM output (unregistered).

## Operation
- Requester X is requesting when mX_read | mX_write. If both are high, the access is a write and the read is dropped.
- Grant is combinational from the current requests and the registered state:
  - Only one requester active: that requester is granted.
  - Both active, FIXED_PRIO=0: grant the requester that is not last_grant.
  - Both active, FIXED_PRIO=1: grant m0 unless starve_cnt == STARVE_LIMIT, in which case grant m1.
- Granted requester: waitrequest=0. Its address, byteenable and writedata are muxed to ram_*. ram_chipselect=1. ram_write=its write.
- Non-granted requester: waitrequest=1. It holds its request stable (Avalon rule).
- No request: ram_chipselect=0, ram_write=0, ram_address holds its last value, waitrequest=1 on both ports.
- ram_clken=1 whenever reset_n=1.
- Acceptance (a rising edge with request=1 and waitrequest=0):
  - last_grant <= X.
  - For a read: rd_pend <= 1, rd_owner <= X. Otherwise rd_pend <= 0.
- starve_cnt (4 bit):
  - Increments on an m0 acceptance while m1 is requesting.
  - Clears on any m1 acceptance, or on a cycle where m1 is not requesting.
  - Saturates at STARVE_LIMIT.
- mX_readdatavalid = rd_pend & (rd_owner == X). Both mX_readdata are driven from ram_readdata. Software must qualify readdata with readdatavalid.
- Reset (async assert, sync-safe deassert):
  - last_grant=1, so m0 wins the first tie.
  - rd_pend=0, rd_owner=0, starve_cnt=0.
  - Both waitrequest=1, both readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0.
  - Reset asserted mid-read discards the pending read; no readdatavalid is produced for it after reset.

## Timing
- Acceptance at edge N means the RAM samples the address at edge N. Read data and readdatavalid are high during cycle N+1 and are sampled by the master at edge N+1. Read latency is 1, fixed.
- Fully pipelined: one access per cycle, with back-to-back accepts from the same or alternating masters. There are no bubbles between grants.
- Write then read of the same address on consecutive cycles returns the new data (single-port RAM, new-data behaviour).
- Round-robin with both masters requesting continuously gives an alternating grant pattern: m0, m1, m0, m1…
- FIXED_PRIO=1 with both masters requesting continuously gives STARVE_LIMIT m0 grants followed by 1 m1 grant, repeating.
- waitrequest depends combinationally on the mX request inputs. There is no combinational path from waitrequest back to the request inputs.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then m0 reads 0x005. Expected: write accepted with 0 wait cycles; m0_readdatavalid exactly one cycle after the read accept with data 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: write 0x11223344 to address 0x3FF, then write 0xAA000000 with byteenable 0x8, then read. Expected: 0xAA223344; wrap-around address 0x3FF handled correctly.
- Both masters issue a read on the same cycle for 8 cycles, FIXED_PRIO=0. Expected: m0 is granted first, then strict alternation; each readdatavalid goes only to its owner, with the data at that owner's address.
- FIXED_PRIO=1, STARVE_LIMIT=4, both masters request continuously for 20 cycles. Expected grant sequence: m0 ×4, m1, repeated 4 times.
- m0 asserts read and write together on address 0x010 with data 0x5. Expected: treated as a write (memory holds 0x5); no readdatavalid.
- reset_n is pulled low in the cycle after a read accept. Expected: the readdatavalid pulse is suppressed; all outputs take their reset values immediately, asynchronously.
